// File: rtl/keypad_event_queue_if.sv
// Event interface between the keypad event queue and the calculator control.
//   ready   : consumer accepts the head event this cycle
//   valid   : head event available
//   code    : key code of the head event (bit index in the key snapshot)
//   level   : number of queued events (0..DEPTH)
//   dropped : one-cycle pulse when a fresh press was lost
// Modport master is the queue side, slave is the consumer side.
interface keypad_event_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          ready;
    logic          valid;
    logic [3:0]    code;
    logic [LW-1:0] level;
    logic          dropped;

    modport master (
        input  ready,
        output valid,
        output code,
        output level,
        output dropped
    );

    modport slave (
        output ready,
        input  valid,
        input  code,
        input  level,
        input  dropped
    );
endinterface

// File: rtl/keypad_event_queue.sv
// Keypad event queue: turns 16-bit debounced key snapshots into discrete
// press events (with auto-repeat for a single held key), buffers them in a
// small FIFO and hands them out over a valid/ready handshake.
//   Clock : system clock
//   Reset : asynchronous, active-low reset
//   keys  : debounced key state, bit 4*r+c = line r / column c, 1 = pressed
//   evq   : event interface (master side): ready in; valid, code, level,
//           dropped out
module keypad_event_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [15:0]                  keys,
    keypad_event_queue_if.master         evq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [15:0]   prev_q;
    logic [15:0]   pending_q, pending_d;
    logic [31:0]   rpt_cnt_q, rpt_cnt_d;
    logic [3:0]    fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          dropped_q;

    logic [15:0]   edges;
    logic [15:0]   rep;
    logic [15:0]   req;
    logic [3:0]    sel;
    logic          eligible;
    logic          rep_fire;
    logic          pop;
    logic          push;
    logic          drop;

    assign edges = keys & ~prev_q;

    // Auto-repeat only for exactly one key held steady since last cycle.
    assign eligible = (REPEAT_DELAY != 0) && $onehot(keys) && (keys == prev_q);
    assign rep_fire = eligible && (rpt_cnt_q == 32'(REPEAT_DELAY - 1));
    assign rep      = rep_fire ? keys : 16'h0000;

    assign req  = pending_q | edges | rep;
    // Only a fresh edge on an already-owed key counts as a lost press;
    // repeats colliding with a pending bit merge silently.
    assign drop = |(edges & pending_q);

    always_comb begin
        sel = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                sel = 4'(i);
            end
        end
    end

    assign pop  = (level_q != '0) && evq.ready;
    // A pop in the same cycle frees the slot even when full.
    assign push = (|req) && ((level_q < LW'(DEPTH)) || pop);

    always_comb begin
        pending_d = req;
        if (push) begin
            pending_d[sel] = 1'b0;
        end
    end

    always_comb begin
        if (!eligible) begin
            rpt_cnt_d = 32'd0;
        end else if (rep_fire) begin
            rpt_cnt_d = 32'(REPEAT_DELAY - REPEAT_RATE);
        end else begin
            rpt_cnt_d = rpt_cnt_q + 32'd1;
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prev_q    <= 16'h0000;
            pending_q <= 16'h0000;
            rpt_cnt_q <= 32'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            dropped_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= 4'd0;
            end
        end else begin
            prev_q    <= keys;
            pending_q <= pending_d;
            rpt_cnt_q <= rpt_cnt_d;
            level_q   <= level_d;
            dropped_q <= drop;
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign evq.valid   = (level_q != '0);
    assign evq.code    = fifo_q[rd_ptr_q];
    assign evq.level   = level_q;
    assign evq.dropped = dropped_q;
endmodule
